// File: rtl/instruction_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder: formats, error codes,
// opcodes and the FIFO entry layout.
package instruction_encoder_pkg;

  typedef enum logic [2:0] {
    INS_R       = 3'd0,
    INS_I       = 3'd1,
    INS_S       = 3'd2,
    INS_B       = 3'd3,
    INS_U       = 3'd4,
    INS_J       = 3'd5,
    INS_INVALID = 3'd6
  } instype_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_TYPE  = 3'd1,
    ERR_ALIGN = 3'd2,
    ERR_RANGE = 3'd3
  } enc_err_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    enc_err_t    err;
  } enc_entry_t;

  // Same opcode/format pairing the decoder uses.
  function automatic logic op_legal(input instype_t t, input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (t)
      INS_R:   ok = (op == OP_REG);
      INS_I:   ok = (op == OP_IMM) || (op == OP_LOAD) || (op == OP_JALR);
      INS_S:   ok = (op == OP_STORE);
      INS_B:   ok = (op == OP_BRANCH);
      INS_U:   ok = (op == OP_LUI) || (op == OP_AUIPC);
      INS_J:   ok = (op == OP_JAL);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when imm is a sign extension of its bits [msb:0].
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] hi;
    hi = $signed(imm) >>> msb;
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// DEPTH-entry output FIFO for encoded words. Head outputs show the last popped entry
// while empty, so downstream never sees stale slots from earlier wraps.
module enc_fifo
  import instruction_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  enc_entry_t i_data,
  input  logic       i_pop,
  output enc_entry_t o_data,
  output logic       o_valid,
  output logic       o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  enc_entry_t        r_mem [DEPTH];
  enc_entry_t        r_last;
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;

  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_last <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) begin
        r_last <= r_mem[r_rd];
        r_rd   <= r_rd + AW'(1);
      end
      if (w_do_push && !w_do_pop) r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? r_last : r_mem[r_rd];

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields into instruction words, range/format checks them, tags
// each with a target address and queues the result for the instruction-memory writer.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [9:0]  in_func,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  instype_t    in_type,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output enc_err_t    out_err,
  output logic        err_sticky
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready may depend on out_ready (pop-through when full).

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_is_shift;
  logic [31:0] w_raw;
  logic        w_type_err;
  logic        w_align_err;
  logic        w_range_err;
  enc_err_t    w_err;
  logic [31:0] w_load_addr;
  logic [31:0] w_entry_addr;
  logic        w_push;
  logic        w_full;
  enc_entry_t  w_wr_entry;
  enc_entry_t  w_head;

  logic [31:0] r_addr;
  logic        r_sticky;

  assign w_f3       = in_func[2:0];
  assign w_f7       = in_func[9:3];
  assign w_is_shift = (in_type == INS_I) && (in_op == OP_IMM) &&
                      ((w_f3 == 3'b001) || (w_f3 == 3'b101));

  always_comb begin
    w_raw = '0;
    case (in_type)
      INS_R: w_raw = {w_f7, in_rs2, in_rs1, w_f3, in_rd, in_op};
      INS_I: w_raw = w_is_shift ? {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, in_op}
                                : {in_imm[11:0], in_rs1, w_f3, in_rd, in_op};
      INS_S: w_raw = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], in_op};
      INS_B: w_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                      in_imm[4:1], in_imm[11], in_op};
      INS_U: w_raw = {in_imm[31:12], in_rd, in_op};
      INS_J: w_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: w_raw = '0;
    endcase
  end

  assign w_type_err = !op_legal(in_type, in_op);

  always_comb begin
    w_align_err = 1'b0;
    w_range_err = 1'b0;
    case (in_type)
      INS_I: w_range_err = w_is_shift ? (in_imm[31:5] != '0) : !fits_signed(in_imm, 11);
      INS_S: w_range_err = !fits_signed(in_imm, 11);
      INS_B: begin
        w_align_err = in_imm[0];
        w_range_err = !fits_signed(in_imm, 12);
      end
      INS_U: w_align_err = (in_imm[11:0] != '0);
      INS_J: begin
        w_align_err = in_imm[0];
        w_range_err = !fits_signed(in_imm, 20);
      end
      default: begin
        w_align_err = 1'b0;
        w_range_err = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_err = ERR_NONE;
    if (w_type_err)       w_err = ERR_TYPE;
    else if (w_align_err) w_err = ERR_ALIGN;
    else if (w_range_err) w_err = ERR_RANGE;
  end

  assign w_load_addr  = {addr_value[31:2], 2'b00};
  assign w_entry_addr = addr_load ? w_load_addr : r_addr;

  assign in_ready = !w_full || (out_valid && out_ready);
  assign w_push   = in_valid && in_ready;

  assign w_wr_entry.instr = (w_err == ERR_NONE) ? w_raw : NOP_WORD;
  assign w_wr_entry.addr  = w_entry_addr;
  assign w_wr_entry.err   = w_err;

  // Errored words keep the address so the next good word lands where it was meant to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= BASE_ADDR;
      r_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_addr <= (w_err == ERR_NONE) ? (w_entry_addr + 32'd4) : w_entry_addr;
        if (w_err != ERR_NONE) r_sticky <= 1'b1;
      end else if (addr_load) begin
        r_addr <= w_load_addr;
      end
    end
  end

  enc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_wr_entry),
    .i_pop  (out_ready),
    .o_data (w_head),
    .o_valid(out_valid),
    .o_full (w_full)
  );

  assign out_instr  = w_head.instr;
  assign out_addr   = w_head.addr;
  assign out_err    = w_head.err;
  assign err_sticky = r_sticky;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encodings, error priority, address counter,
// FIFO backpressure/pop-through and mid-stream reset.
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [9:0]  in_func;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  instype_t    in_type;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  enc_err_t    out_err;
  logic        err_sticky;

  int checks = 0;
  int errors = 0;

  instruction_encoder #(.DEPTH(2), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_type(in_type), .addr_load(addr_load),
    .addr_value(addr_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] instr,
                          input logic [31:0] addr, input logic [2:0] err);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_addr"}, out_addr, addr);
    chk({tag, "_err"}, {29'b0, out_err}, {29'b0, err});
  endtask

  task automatic drive(input logic [6:0] op, input logic [9:0] func, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                       input instype_t t);
    in_op    = op;
    in_func  = func;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_imm   = imm;
    in_type  = t;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [9:0] func, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                      input instype_t t);
    drive(op, func, rs1, rs2, rd, imm, t);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = '0;
    in_op = '0; in_func = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    in_type = INS_R;
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_err", {29'b0, out_err}, 32'd0);
    chk("rst_sticky", {31'b0, err_sticky}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    #10 rst_n = 1'b1;
    @(negedge clk);

    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5, INS_I);
    chk_word("addi", 32'h0050_0093, 32'h0, 3'd0);
    send(OP_STORE, 10'h002, 5'd1, 5'd2, 5'd0, 32'd8, INS_S);
    chk_word("sw", 32'h0020_A423, 32'h4, 3'd0);
    send(OP_LUI, 10'h000, 5'd0, 5'd0, 5'd5, 32'h1234_5000, INS_U);
    chk_word("lui", 32'h1234_52B7, 32'h8, 3'd0);
    send(OP_JAL, 10'h000, 5'd0, 5'd0, 5'd1, 32'd2048, INS_J);
    chk_word("jal", 32'h0010_00EF, 32'hC, 3'd0);
    chk("sticky_clean", {31'b0, err_sticky}, 32'd0);

    send(OP_BRANCH, 10'h000, 5'd1, 5'd2, 5'd0, 32'd3, INS_B);
    chk_word("beq_align", 32'h0000_0013, 32'h10, 3'd2);
    chk("sticky_set", {31'b0, err_sticky}, 32'd1);
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd2048, INS_I);
    chk_word("addi_range", 32'h0000_0013, 32'h10, 3'd3);
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5, INS_INVALID);
    chk_word("invalid", 32'h0000_0013, 32'h10, 3'd1);
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5, INS_R);
    chk_word("op_mismatch", 32'h0000_0013, 32'h10, 3'd1);
    send(OP_IMM, 10'h001, 5'd1, 5'd0, 5'd1, 32'd32, INS_I);
    chk_word("slli_range", 32'h0000_0013, 32'h10, 3'd3);
    send(OP_LUI, 10'h000, 5'd0, 5'd0, 5'd5, 32'h1234_5001, INS_U);
    chk_word("lui_align", 32'h0000_0013, 32'h10, 3'd2);
    send(OP_BRANCH, 10'h000, 5'd1, 5'd2, 5'd0, 32'd4096, INS_B);
    chk_word("beq_range", 32'h0000_0013, 32'h10, 3'd3);

    send(OP_IMM, 10'h001, 5'd1, 5'd0, 5'd1, 32'd3, INS_I);
    chk_word("slli", 32'h0030_9093, 32'h10, 3'd0);
    send(OP_BRANCH, 10'h000, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, INS_B);
    chk_word("beq_neg", 32'hFE20_8EE3, 32'h14, 3'd0);
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, INS_I);
    chk_word("addi_min", 32'h8000_0093, 32'h18, 3'd0);

    @(posedge clk); #1;
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_hold", out_instr, 32'h8000_0093);

    out_ready = 1'b0;
    drive(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd1, INS_I);
    @(posedge clk); #1;
    chk("bp_ready1", {31'b0, in_ready}, 32'd1);
    drive(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd2, 32'd2, INS_I);
    @(posedge clk); #1;
    chk("bp_full", {31'b0, in_ready}, 32'd0);
    drive(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd3, 32'd3, INS_I);
    @(posedge clk); #1;
    chk("bp_stall", {31'b0, in_ready}, 32'd0);
    chk_word("bp_head", 32'h0010_0093, 32'h1C, 3'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_through", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_word("bp_second", 32'h0020_0113, 32'h20, 3'd0);
    @(posedge clk); #1;
    chk_word("bp_third", 32'h0030_0193, 32'h24, 3'd0);
    @(posedge clk); #1;
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    addr_load = 1'b1; addr_value = 32'h0000_0103;
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5, INS_I);
    addr_load = 1'b0;
    chk_word("load_first", 32'h0050_0093, 32'h100, 3'd0);
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5, INS_I);
    chk_word("load_next", 32'h0050_0093, 32'h104, 3'd0);

    out_ready = 1'b0;
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd2, 32'd2, INS_I);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'h0);
    chk("mid_rst_addr", out_addr, 32'h0);
    chk("mid_rst_sticky", {31'b0, err_sticky}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(OP_IMM, 10'h000, 5'd0, 5'd0, 5'd1, 32'd5, INS_I);
    chk_word("post_rst", 32'h0050_0093, 32'h0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
